// File: rtl/red_pitaya_asg_seq.sv
// red_pitaya_asg_seq
//   Segment sequencer for one ASG channel. Produces the per-sample read
//   address for the channel's table RAM by playing up to NSEG programmable
//   segments (offset, end pointer, step, cycle count) in order, optionally
//   looping back to segment 0.
//
//   Segment registers are double buffered: writes land in per-slot shadow
//   registers at any time, and the active copy is loaded from the shadow slot
//   when a segment is entered.
//
//   Optional feature macro: ASG_SEQ_GAP_EN adds a per-segment idle gap
//   (field 4) played between segments. When undefined, field 4 writes are
//   ignored and there is no GAP state.
//
// Ports
//   dac_clk_i, dac_rst_i     clock, synchronous active-high reset
//   cfg_we_i/seg_i/fld_i     shadow register write (fld 0=off 1=end 2=step
//   cfg_wdata_i              3=ncyc 4=gap); pointer fields use [RSZ+FRAC-1:0]
//   nseg_i, loop_i           active segment count (0 means 1), loop enable
//   arm_i, stop_i, trig_i    arm pulse, abort pulse, trigger level
//   rd_addr_o, rd_vld_o      table read address and its valid flag
//   seg_o, busy_o            active segment index, sequencer not idle
//   seg_chg_o, done_o        segment-entry pulse, sequence-end pulse
module red_pitaya_asg_seq #(
  parameter int RSZ  = 14,
  parameter int FRAC = 16,
  parameter int NSEG = 4,
  parameter int CYW  = 16
) (
  input  logic                    dac_clk_i,
  input  logic                    dac_rst_i,
  input  logic                    cfg_we_i,
  input  logic [$clog2(NSEG)-1:0] cfg_seg_i,
  input  logic [2:0]              cfg_fld_i,
  input  logic [31:0]             cfg_wdata_i,
  input  logic [$clog2(NSEG):0]   nseg_i,
  input  logic                    loop_i,
  input  logic                    arm_i,
  input  logic                    stop_i,
  input  logic                    trig_i,
  output logic [RSZ-1:0]          rd_addr_o,
  output logic                    rd_vld_o,
  output logic [$clog2(NSEG)-1:0] seg_o,
  output logic                    busy_o,
  output logic                    seg_chg_o,
  output logic                    done_o
);
  localparam int PW = RSZ + FRAC;
  localparam int SW = $clog2(NSEG);
`ifdef ASG_SEQ_GAP_EN
  localparam int GW = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
`ifdef ASG_SEQ_GAP_EN
    S_GAP,
`endif
    S_RUN
  } state_t;

  // Shadow slot registers, exposed as arrays for indexed reads.
  logic [PW-1:0]  sh_off  [NSEG];
  logic [PW-1:0]  sh_end  [NSEG];
  logic [PW-1:0]  sh_step [NSEG];
  logic [CYW-1:0] sh_ncyc [NSEG];
`ifdef ASG_SEQ_GAP_EN
  logic [GW-1:0]  sh_gap  [NSEG];
`endif

  // Pointer bits above PW are never used.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata_i[31:PW];

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_slot
      logic [PW-1:0]  off_q, end_q, step_q;
      logic [CYW-1:0] ncyc_q;
      logic           slot_we;
`ifdef ASG_SEQ_GAP_EN
      logic [GW-1:0]  gap_q;
`endif
      assign slot_we = cfg_we_i && (cfg_seg_i == SW'(gi));

      always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
          off_q  <= '0;
          end_q  <= '0;
          step_q <= '0;
          ncyc_q <= '0;
`ifdef ASG_SEQ_GAP_EN
          gap_q  <= '0;
`endif
        end else if (slot_we) begin
          case (cfg_fld_i)
            3'd0:    off_q  <= cfg_wdata_i[PW-1:0];
            3'd1:    end_q  <= cfg_wdata_i[PW-1:0];
            3'd2:    step_q <= cfg_wdata_i[PW-1:0];
            3'd3:    ncyc_q <= cfg_wdata_i[CYW-1:0];
`ifdef ASG_SEQ_GAP_EN
            3'd4:    gap_q  <= cfg_wdata_i[GW-1:0];
`endif
            default: ;
          endcase
        end
      end

      assign sh_off[gi]  = off_q;
      assign sh_end[gi]  = end_q;
      assign sh_step[gi] = step_q;
      assign sh_ncyc[gi] = ncyc_q;
`ifdef ASG_SEQ_GAP_EN
      assign sh_gap[gi]  = gap_q;
`endif
    end
  endgenerate

  state_t         state_q, state_d;
  logic [SW-1:0]  seg_q, seg_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CYW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]  a_off_q, a_off_d, a_end_q, a_end_d, a_step_q, a_step_d;
  logic [CYW-1:0] a_ncyc_q, a_ncyc_d;
`ifdef ASG_SEQ_GAP_EN
  logic [GW-1:0]  a_gap_q, a_gap_d, gcnt_q, gcnt_d;
`endif
  logic           chg_q, chg_d, done_q, done_d, trig_q;

  logic [PW:0]    nxt;       // one extra bit so a pointer past the table top still compares as > end
  logic [CYW:0]   cnt_inc;
  logic [SW:0]    nseg_eff;
  logic           trig_edge, wrap_ok, seq_more, enter;
  logic [SW-1:0]  seg_next, enter_seg;

  assign trig_edge = trig_i && !trig_q;
  assign nxt       = {1'b0, ptr_q} + {1'b0, a_step_q};
  assign cnt_inc   = {1'b0, cnt_q} + (CYW+1)'(1);
  assign wrap_ok   = (a_ncyc_q == '0) || (cnt_inc < {1'b0, a_ncyc_q});
  // nseg of 0 plays one segment; larger than NSEG is clamped
  assign nseg_eff  = (nseg_i == '0)                ? (SW+1)'(1)    :
                     (nseg_i > (SW+1)'(NSEG))      ? (SW+1)'(NSEG) : nseg_i;
  assign seq_more  = (({1'b0, seg_q} + (SW+1)'(1)) < nseg_eff);
  assign seg_next  = seq_more ? (seg_q + SW'(1)) : '0;

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    a_off_d   = a_off_q;
    a_end_d   = a_end_q;
    a_step_d  = a_step_q;
    a_ncyc_d  = a_ncyc_q;
`ifdef ASG_SEQ_GAP_EN
    a_gap_d   = a_gap_q;
    gcnt_d    = gcnt_q;
`endif
    chg_d     = 1'b0;
    done_d    = 1'b0;
    enter     = 1'b0;
    enter_seg = '0;

    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (arm_i) state_d = S_ARMED;
        S_ARMED: if (trig_edge) begin
          enter     = 1'b1;
          enter_seg = '0;
        end
        S_RUN: begin
          if (nxt <= {1'b0, a_end_q}) begin
            ptr_d = nxt[PW-1:0];
          end else if (wrap_ok) begin
            // wrap restarts exactly at the offset; the fraction is dropped
            ptr_d = a_off_q;
            cnt_d = cnt_inc[CYW-1:0];
          end else begin
            cnt_d = '0;
            if (seq_more || loop_i) begin
`ifdef ASG_SEQ_GAP_EN
              if (a_gap_q != '0) begin
                state_d = S_GAP;
                seg_d   = seg_next;
                gcnt_d  = a_gap_q;
              end else begin
                enter     = 1'b1;
                enter_seg = seg_next;
              end
`else
              enter     = 1'b1;
              enter_seg = seg_next;
`endif
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
`ifdef ASG_SEQ_GAP_EN
        S_GAP: begin
          if (gcnt_q == GW'(1)) begin
            enter     = 1'b1;
            enter_seg = seg_q;
          end else begin
            gcnt_d = gcnt_q - GW'(1);
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    // Segment entry: snapshot the shadow slot and emit its first sample.
    if (enter) begin
      state_d  = S_RUN;
      seg_d    = enter_seg;
      ptr_d    = sh_off[enter_seg];
      a_off_d  = sh_off[enter_seg];
      a_end_d  = sh_end[enter_seg];
      a_step_d = sh_step[enter_seg];
      a_ncyc_d = sh_ncyc[enter_seg];
`ifdef ASG_SEQ_GAP_EN
      a_gap_d  = sh_gap[enter_seg];
`endif
      cnt_d    = '0;
      chg_d    = 1'b1;
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q  <= S_IDLE;
      seg_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      a_off_q  <= '0;
      a_end_q  <= '0;
      a_step_q <= '0;
      a_ncyc_q <= '0;
`ifdef ASG_SEQ_GAP_EN
      a_gap_q  <= '0;
      gcnt_q   <= '0;
`endif
      chg_q    <= 1'b0;
      done_q   <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      a_off_q  <= a_off_d;
      a_end_q  <= a_end_d;
      a_step_q <= a_step_d;
      a_ncyc_q <= a_ncyc_d;
`ifdef ASG_SEQ_GAP_EN
      a_gap_q  <= a_gap_d;
      gcnt_q   <= gcnt_d;
`endif
      chg_q    <= chg_d;
      done_q   <= done_d;
      trig_q   <= trig_i;
    end
  end

  assign rd_addr_o = ptr_q[PW-1:FRAC];
  assign rd_vld_o  = (state_q == S_RUN);
  assign seg_o     = seg_q;
  assign busy_o    = (state_q != S_IDLE);
  assign seg_chg_o = chg_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_red_pitaya_asg_seq.sv
// Testbench for red_pitaya_asg_seq. A reference model expands each programmed
// segment table into the list of expected samples / done event; a monitor
// compares those against the DUT whenever it presents rd_vld_o or done_o.
module tb_red_pitaya_asg_seq;
  localparam int RSZ  = 14;
  localparam int FRAC = 16;
  localparam int NSEG = 4;
  localparam int CYW  = 16;
`ifdef ASG_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           dac_rst_i = 1'b1;
  logic           cfg_we_i = 1'b0;
  logic [1:0]     cfg_seg_i = '0;
  logic [2:0]     cfg_fld_i = '0;
  logic [31:0]    cfg_wdata_i = '0;
  logic [2:0]     nseg_i = '0;
  logic           loop_i = 1'b0;
  logic           arm_i = 1'b0;
  logic           stop_i = 1'b0;
  logic           trig_i = 1'b0;
  logic [RSZ-1:0] rd_addr_o;
  logic           rd_vld_o;
  logic [1:0]     seg_o;
  logic           busy_o;
  logic           seg_chg_o;
  logic           done_o;

  red_pitaya_asg_seq #(.RSZ(RSZ), .FRAC(FRAC), .NSEG(NSEG), .CYW(CYW)) dut (
    .dac_clk_i(clk), .dac_rst_i(dac_rst_i),
    .cfg_we_i(cfg_we_i), .cfg_seg_i(cfg_seg_i), .cfg_fld_i(cfg_fld_i), .cfg_wdata_i(cfg_wdata_i),
    .nseg_i(nseg_i), .loop_i(loop_i), .arm_i(arm_i), .stop_i(stop_i), .trig_i(trig_i),
    .rd_addr_o(rd_addr_o), .rd_vld_o(rd_vld_o), .seg_o(seg_o), .busy_o(busy_o),
    .seg_chg_o(seg_chg_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // kind 0 = sample, 1 = done pulse; bub = idle cycles before this event
  typedef struct { int kind; int addr; int seg; int chg; int bub; int first; } item_t;
  item_t exp_q[$];
  int start_cyc = 0;

  // Reference configuration: version 0 / 1 lets a table change take effect
  // from entry number m_swap_ent onward.
  longint m_off[2][NSEG], m_end[2][NSEG], m_step[2][NSEG], m_ncyc[2][NSEG], m_gap[2][NSEG];
  int m_nseg = 1, m_loop = 0, m_swap_ent = 1000000;

  // Expand the sequence into expected events; lim>0 truncates to lim samples.
  task automatic build(input int lim);
    int s, ent, n, neff, v, pass, bub, first, chg;
    longint o, e, st, nc, g, ptr, nxt;
    item_t it;
    s = 0; ent = 0; n = 0; bub = 0; first = 1;
    neff = (m_nseg == 0) ? 1 : ((m_nseg > NSEG) ? NSEG : m_nseg);
    while (n < 4000) begin
      v = (ent >= m_swap_ent) ? 1 : 0;
      o = m_off[v][s]; e = m_end[v][s]; st = m_step[v][s]; nc = m_ncyc[v][s]; g = m_gap[v][s];
      ptr = o; pass = 0; chg = 1;
      forever begin
        it = '{0, int'(ptr >> FRAC), s, chg, bub, first};
        exp_q.push_back(it);
        n++; chg = 0; bub = 0; first = 0;
        if ((lim != 0 && n == lim) || n >= 4000) return;
        nxt = ptr + st;
        if (nxt <= e) ptr = nxt;
        else begin
          pass++;
          if (nc == 0 || pass < nc) ptr = o;
          else break;
        end
      end
      ent++;
      if (s < neff - 1) s++;
      else if (m_loop != 0) s = 0;
      else begin
        it = '{1, 0, 0, 0, 0, 0};
        exp_q.push_back(it);
        return;
      end
      bub = GAP_EN ? int'(g) : 0;
    end
  endtask

  // Monitor: pop and compare whenever the DUT shows a sample or a done pulse.
  int mon_last = 0;
  initial begin
    item_t it;
    int sp;
    forever begin
      @(negedge clk);
      if (rd_vld_o || done_o) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          it = exp_q.pop_front();
          sp = (it.first != 0) ? (cyc - start_cyc - 1) : (cyc - mon_last - 1);
          chk("spacing", sp, it.bub);
          if (it.kind == 0) begin
            chk("rd_vld", rd_vld_o, 1);
            chk("rd_addr", rd_addr_o, it.addr);
            chk("seg_o", seg_o, it.seg);
            chk("seg_chg", seg_chg_o, it.chg);
            chk("busy_run", busy_o, 1);
          end else begin
            chk("done_o", done_o, 1);
            chk("rd_vld_at_done", rd_vld_o, 0);
            chk("busy_at_done", busy_o, 0);
          end
        end
        mon_last = cyc;
      end
    end
  end

  task automatic wr(input int s, input int f, input longint d);
    @(negedge clk);
    cfg_we_i = 1'b1; cfg_seg_i = s[1:0]; cfg_fld_i = f[2:0]; cfg_wdata_i = d[31:0];
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic program_seg(input int s, input longint off, input longint en, input longint st,
                             input longint nc, input longint gp);
    wr(s, 0, off); wr(s, 1, en); wr(s, 2, st); wr(s, 3, nc); wr(s, 4, gp);
    for (int v = 0; v < 2; v++) begin
      m_off[v][s] = off; m_end[v][s] = en; m_step[v][s] = st; m_ncyc[v][s] = nc; m_gap[v][s] = gp;
    end
  endtask

  task automatic set_seq(input int ns, input int lp);
    nseg_i = ns[2:0]; loop_i = lp[0]; m_nseg = ns; m_loop = lp;
  endtask

  // mode 0: run to done; 1: stop_i after lim samples; 2: reset after lim samples.
  // wr_at>0 writes seg0 step=wr_data during play.
  task automatic run_case(input int lim, input int mode, input int wr_at, input longint wr_data);
    int k;
    build(mode == 0 ? 0 : lim);
    @(negedge clk); arm_i = 1'b1;
    @(negedge clk); arm_i = 1'b0; trig_i = 1'b1; start_cyc = cyc;
    if (mode == 0) begin
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
        @(negedge clk); trig_i = 1'b0; k++;
      end
      trig_i = 1'b0;
      chk("sequence_completes", exp_q.size(), 0);
      @(negedge clk);
      chk("idle_after_done", busy_o, 0);
    end else begin
      for (int i = 1; i < lim; i++) begin
        @(negedge clk); trig_i = 1'b0; cfg_we_i = 1'b0;
        if (i == wr_at) begin
          cfg_we_i = 1'b1; cfg_seg_i = 2'd0; cfg_fld_i = 3'd2; cfg_wdata_i = wr_data[31:0];
        end
      end
      @(negedge clk); trig_i = 1'b0; cfg_we_i = 1'b0;
      if (mode == 1) stop_i = 1'b1; else dac_rst_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      chk("halt_rd_vld", rd_vld_o, 0);
      chk("halt_busy", busy_o, 0);
      chk("halt_no_done", done_o, 0);
      if (mode == 2) begin
        chk("rst_rd_addr", rd_addr_o, 0);
        chk("rst_seg", seg_o, 0);
        chk("rst_seg_chg", seg_chg_o, 0);
        dac_rst_i = 1'b0;
      end
      chk("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint off, en, st;
    int len;
    repeat (3) @(negedge clk);
    chk("reset_rd_addr", rd_addr_o, 0);
    chk("reset_rd_vld", rd_vld_o, 0);
    chk("reset_seg", seg_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_seg_chg", seg_chg_o, 0);
    chk("reset_done", done_o, 0);
    dac_rst_i = 1'b0;

    // single segment, two passes; seg0 gap is skipped at sequence end
    program_seg(0, 0, 3 << 16, 1 << 16, 2, 5);
    set_seq(1, 0);
    run_case(0, 0, -1, 0);

    // trig held high while arming is not an edge
    trig_i = 1'b1;
    @(negedge clk); arm_i = 1'b1;
    @(negedge clk); arm_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("armed_busy", busy_o, 1);
    chk("held_trig_no_play", rd_vld_o, 0);
    stop_i = 1'b1;
    @(negedge clk); stop_i = 1'b0; trig_i = 1'b0;
    chk("stop_from_armed", busy_o, 0);

    // two segments back to back (gap after seg0 only when gaps exist)
    program_seg(1, 'h100 << 16, 'h103 << 16, 1 << 16, 1, 3);
    set_seq(2, 0);
    run_case(0, 0, -1, 0);

    // half step
    program_seg(0, 0, 2 << 16, 'h8000, 1, 0);
    set_seq(1, 0);
    run_case(0, 0, -1, 0);

    // pointer near the table top: next pointer exceeds the pointer width
    program_seg(0, 'h3FFE0000, 'h3FFFFFFF, 'h30000, 2, 0);
    run_case(0, 0, -1, 0);

    // end < off plays one sample per pass
    program_seg(0, 5 << 16, 2 << 16, 1 << 16, 3, 0);
    run_case(0, 0, -1, 0);

    // endless seg0, aborted by stop_i
    program_seg(0, 0, 3 << 16, 1 << 16, 0, 0);
    program_seg(1, 'h200 << 16, 'h201 << 16, 1 << 16, 1, 0);
    set_seq(2, 1);
    run_case(20, 1, -1, 0);

    // stop_i together with a trigger edge keeps the sequencer idle
    @(negedge clk); arm_i = 1'b1;
    @(negedge clk); arm_i = 1'b0; trig_i = 1'b1; stop_i = 1'b1;
    @(negedge clk); stop_i = 1'b0;
    chk("stop_trig_busy", busy_o, 0);
    @(negedge clk);
    chk("stop_trig_rd_vld", rd_vld_o, 0);
    trig_i = 1'b0;

    // mid-segment step write applies at the next entry of seg0
    program_seg(0, 0, 7 << 16, 1 << 16, 1, 0);
    set_seq(1, 1);
    m_step[1][0] = 2 << 16;
    m_swap_ent = 1;
    run_case(16, 1, 3, 2 << 16);
    m_swap_ent = 1000000;

    // reset in the middle of play
    program_seg(0, 'h10 << 16, 'h20 << 16, 'h18000, 0, 0);
    set_seq(1, 0);
    run_case(7, 2, -1, 0);

    // randomized tables
    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s < NSEG; s++) begin
        off = (longint'($urandom_range(0, 16383)) << 16) | longint'($urandom_range(0, 65535));
        len = int'($urandom_range(0, 5));
        if ($urandom_range(0, 7) == 0) en = (off >= 'h30000) ? off - 'h30000 : off;
        else en = off + (longint'(len) << 16) + longint'($urandom_range(0, 65535));
        if (en > 'h3FFFFFFF) en = 'h3FFFFFFF;
        st = longint'($urandom_range('h4000, 'h28000));
        program_seg(s, off, en, st, longint'($urandom_range(1, 3)), longint'($urandom_range(0, 4)));
      end
      set_seq(int'($urandom_range(0, NSEG)), 0);
      run_case(0, 0, -1, 0);
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
